// File: rtl/fta_bus_pkg.sv
// ---------------------------------------------------------------------------
// fta_bus_pkg
// Shared FTA bus types: the 64-bit command request and response channels,
// plus the state encoding of the I/O timeout monitor.
// No ports (package).
// ---------------------------------------------------------------------------
package fta_bus_pkg;

    typedef logic [7:0] fta_tranid_t;

    typedef struct packed {
        logic [2:0]  cti;
        logic [5:0]  blen;
        fta_tranid_t tid;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [7:0]  sel;
        logic [31:0] vadr;
        logic [31:0] padr;
        logic [63:0] data1;
    } fta_cmd_request64_t;

    typedef struct packed {
        fta_tranid_t tid;
        logic [2:0]  pri;
        logic        stall;
        logic        next;
        logic        ack;
        logic        rty;
        logic        err;
        logic [31:0] adr;
        logic [63:0] dat;
    } fta_cmd_response64_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ERR   = 2'd2,
        DRAIN = 2'd3
    } fta_io_timeout_state_t;

    // Value err_adr_o shows when nothing has been logged.
    localparam logic [31:0] FTA_IO_TIMEOUT_ADR_RST = 32'hFFFF_FFFF;
    localparam logic [15:0] FTA_IO_TIMEOUT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/fta_io_timeout_ctr.sv
// ---------------------------------------------------------------------------
// fta_io_timeout_ctr
// Up-counter for the I/O timeout monitor with a terminal-count compare at
// TIMEOUT-1.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset (count forced to 0)
//   clr    - synchronous clear to 0 (wins over en)
//   en     - count up by one
//   tc     - count equals TIMEOUT-1
// ---------------------------------------------------------------------------
module fta_io_timeout_ctr #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNTW    = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // TIMEOUT may equal 2**CNTW, so TIMEOUT-1 always fits in CNTW bits.
    localparam logic [CNTW-1:0] TC_VAL = CNTW'(TIMEOUT - 1);

    logic [CNTW-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNTW'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/fta_io_timeout64.sv
// ---------------------------------------------------------------------------
// fta_io_timeout64
// Watches the bridge's 64-bit master request and the merged device response.
// If no response with the captured tid arrives within TIMEOUT cycles, it
// emits a single registered error response on resp_o so the master is not
// left hanging.
//
// Ports:
//   clk_i     - clock
//   rst_ni    - asynchronous active-low reset
//   req       - monitored copy of the registered master request
//   resp_i    - monitored merged device response
//   resp_o    - synthesized error response (all-zero except the err pulse)
//   busy_o    - a request is being timed (WAIT or ERR)
//   err_cnt_o - saturating count of timeouts (0 unless logging enabled)
//   err_adr_o - padr of the latest timed-out request (all-ones unless logging)
//
// Build option: define FTA_IO_TIMEOUT_LOG_EN to enable err_cnt_o/err_adr_o
// logging; otherwise both are constants.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request timed; waiting for a new request
// WAIT  | request captured, counting cycles until response or timeout
// ERR   | one cycle; resp_o carries the error pulse
// DRAIN | error issued; wait for cyc to drop or a new tid
// ---------------------------------------------------------------------------
module fta_io_timeout64
    import fta_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNTW    = 10
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  fta_cmd_request64_t  req,
    input  fta_cmd_response64_t resp_i,
    output fta_cmd_response64_t resp_o,
    output logic                busy_o,
    output logic [15:0]         err_cnt_o,
    output logic [31:0]         err_adr_o
);

    fta_io_timeout_state_t state, state_nxt;
    fta_cmd_response64_t   resp_d;

    logic        cyc_q;
    fta_tranid_t cap_tid;
    logic [31:0] cap_padr;
    logic        cap_we;
    logic        capture;
    logic        new_req;
    logic        resp_match;
    logic        ctr_en;
    logic        tc;

    // A held request with an unchanged tid is the same request; only a
    // rising cyc or a tid change starts a new timing window.
    assign new_req    = req.cyc & req.stb & (~cyc_q | (req.tid != cap_tid));
    assign resp_match = (resp_i.ack | resp_i.err | resp_i.rty) &
                        (resp_i.tid == cap_tid);

    fta_io_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNTW    (CNTW)
    ) u_ctr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (capture),
        .en     (ctr_en),
        .tc     (tc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (new_req) begin
                    state_nxt = WAIT;
                    capture   = 1'b1;
                end
            end
            WAIT: begin
                // A matching response beats the terminal count.
                if (resp_match || !req.cyc) begin
                    state_nxt = IDLE;
                end else if (tc) begin
                    state_nxt = ERR;
                end
            end
            ERR: begin
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!req.cyc) begin
                    state_nxt = IDLE;
                end else if (new_req) begin
                    state_nxt = WAIT;
                    capture   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o = (state == WAIT) || (state == ERR);
        ctr_en = (state == WAIT);
        resp_d = '0;
        if (state_nxt == ERR) begin
            resp_d.err = 1'b1;
            resp_d.tid = cap_tid;
            resp_d.adr = cap_padr;
        end
    end

    // Error pulse is registered so it lines up with the ERR state cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_o <= '0;
        end else begin
            resp_o <= resp_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q    <= 1'b0;
            cap_tid  <= '0;
            cap_padr <= '0;
            cap_we   <= 1'b0;
        end else begin
            cyc_q <= req.cyc;
            if (capture) begin
                cap_tid  <= req.tid;
                cap_padr <= req.padr;
                cap_we   <= req.we;
            end
        end
    end

`ifdef FTA_IO_TIMEOUT_LOG_EN
    logic [15:0] err_cnt_q;
    logic [31:0] err_adr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
            err_adr_q <= FTA_IO_TIMEOUT_ADR_RST;
        end else if (state == ERR) begin
            if (err_cnt_q != FTA_IO_TIMEOUT_CNT_MAX) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            err_adr_q <= cap_padr;
        end
    end

    assign err_cnt_o = err_cnt_q;
    assign err_adr_o = err_adr_q;
`else
    assign err_cnt_o = '0;
    assign err_adr_o = FTA_IO_TIMEOUT_ADR_RST;
`endif

    // Reads and writes are timed identically, so the captured we and most
    // request/response fields are observed but not acted on.
    logic unused_bits;
    assign unused_bits = ^{req, resp_i, cap_we};

endmodule

// File: tb/tb_fta_io_timeout64.sv
module tb_fta_io_timeout64;
    import fta_bus_pkg::*;

    localparam int unsigned T  = 1024;
    localparam int unsigned T4 = 4;
`ifdef FTA_IO_TIMEOUT_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    fta_cmd_request64_t  req, req4;
    fta_cmd_response64_t resp_i, resp4_i, resp_o, resp4_o;
    logic                busy_o, busy4_o;
    logic [15:0]         err_cnt_o, err_cnt4_o;
    logic [31:0]         err_adr_o, err_adr4_o;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int pulses = 0, pulse_edge = 0;
    int pulses4 = 0, pulse4_edge = 0;
    int e0, p0;

    fta_io_timeout64 #(.TIMEOUT(T), .CNTW(10)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req       (req),
        .resp_i    (resp_i),
        .resp_o    (resp_o),
        .busy_o    (busy_o),
        .err_cnt_o (err_cnt_o),
        .err_adr_o (err_adr_o)
    );

    fta_io_timeout64 #(.TIMEOUT(T4), .CNTW(2)) dut4 (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req       (req4),
        .resp_i    (resp4_i),
        .resp_o    (resp4_o),
        .busy_o    (busy4_o),
        .err_cnt_o (err_cnt4_o),
        .err_adr_o (err_adr4_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) edge_cnt++;

    always @(negedge clk_i) begin
        if (resp_o != '0) begin
            pulses++;
            pulse_edge = edge_cnt;
        end
        if (resp4_o != '0) begin
            pulses4++;
            pulse4_edge = edge_cnt;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic step_to(input int target);
        while (edge_cnt < target) step(1);
    endtask

    function automatic fta_cmd_request64_t mk_req(input fta_tranid_t t, input logic [31:0] a,
                                                   input logic w);
        fta_cmd_request64_t r;
        r      = '0;
        r.cyc  = 1'b1;
        r.stb  = 1'b1;
        r.tid  = t;
        r.padr = a;
        r.we   = w;
        r.sel  = 8'hFF;
        return r;
    endfunction

    function automatic fta_cmd_response64_t mk_ack(input fta_tranid_t t);
        fta_cmd_response64_t r;
        r     = '0;
        r.ack = 1'b1;
        r.tid = t;
        return r;
    endfunction

    function automatic fta_cmd_response64_t err_pulse(input fta_tranid_t t, input logic [31:0] a);
        fta_cmd_response64_t r;
        r     = '0;
        r.err = 1'b1;
        r.tid = t;
        r.adr = a;
        return r;
    endfunction

    initial begin
        req     = '0;
        req4    = '0;
        resp_i  = '0;
        resp4_i = '0;

        // reset state
        #1;
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_resp", 128'(resp_o), 128'(0));
        chk("rst_cnt", 128'(err_cnt_o), 128'(0));
        chk("rst_adr", 128'(err_adr_o), 128'(32'hFFFF_FFFF));
        step(2);
        rst_ni = 1'b1;
        step(1);

        // read tid 5, ack after 3 busy cycles
        p0  = pulses;
        req = mk_req(8'd5, 32'hFEE0_0010, 1'b0);
        step(1);
        chk("ack_busy1", 128'(busy_o), 128'(1));
        step(1);
        chk("ack_busy2", 128'(busy_o), 128'(1));
        step(1);
        chk("ack_busy3", 128'(busy_o), 128'(1));
        resp_i = mk_ack(8'd5);
        step(1);
        resp_i = '0;
        chk("ack_idle", 128'(busy_o), 128'(0));
        step(5);
        chk("held_no_rearm", 128'(busy_o), 128'(0));
        chk("ack_no_pulse", 128'(pulses), 128'(p0));
        req = '0;
        step(2);

        // read tid 7, no response -> timeout
        p0  = pulses;
        req = mk_req(8'd7, 32'hFEE0_0020, 1'b0);
        e0  = edge_cnt + 1;
        step_to(e0 + T - 1);
        chk("to_busy_pre", 128'(busy_o), 128'(1));
        chk("to_no_early", 128'(pulses), 128'(p0));
        step(1);
        chk("to_pulse", 128'(resp_o), 128'(err_pulse(8'd7, 32'hFEE0_0020)));
        chk("to_busy_err", 128'(busy_o), 128'(1));
        step(1);
        chk("to_resp_clr", 128'(resp_o), 128'(0));
        chk("to_drain_busy", 128'(busy_o), 128'(0));
        chk("to_edge", 128'(pulse_edge), 128'(e0 + T));
        chk("to_cnt", 128'(err_cnt_o), 128'(LOG ? 1 : 0));
        chk("to_adr", 128'(err_adr_o), 128'(LOG ? 32'hFEE0_0020 : 32'hFFFF_FFFF));

        // cyc held through DRAIN, then new tid 8
        step(20);
        chk("drain_busy", 128'(busy_o), 128'(0));
        chk("drain_one_pulse", 128'(pulses), 128'(p0 + 1));
        req = mk_req(8'd8, 32'hFEE0_0030, 1'b0);
        step(1);
        chk("drain_rearm", 128'(busy_o), 128'(1));
        step(2);
        resp_i = mk_ack(8'd8);
        step(1);
        resp_i = '0;
        chk("drain_ack_idle", 128'(busy_o), 128'(0));
        chk("drain_total", 128'(pulses), 128'(p0 + 1));
        req = '0;
        step(2);

        // ack in the exact timeout cycle wins
        p0  = pulses;
        req = mk_req(8'd7, 32'hFEE0_0020, 1'b0);
        e0  = edge_cnt + 1;
        step_to(e0 + T - 1);
        chk("race_busy", 128'(busy_o), 128'(1));
        resp_i = mk_ack(8'd7);
        step(1);
        resp_i = '0;
        chk("race_idle", 128'(busy_o), 128'(0));
        chk("race_resp", 128'(resp_o), 128'(0));
        step(3);
        chk("race_no_pulse", 128'(pulses), 128'(p0));
        chk("race_cnt", 128'(err_cnt_o), 128'(LOG ? 1 : 0));
        req = '0;
        step(2);

        // ack with wrong tid ignored
        p0  = pulses;
        req = mk_req(8'd7, 32'hFEE0_0060, 1'b0);
        e0  = edge_cnt + 1;
        step(5);
        resp_i = mk_ack(8'd3);
        step(1);
        resp_i = '0;
        chk("wtid_busy", 128'(busy_o), 128'(1));
        step_to(e0 + T);
        chk("wtid_pulse", 128'(resp_o), 128'(err_pulse(8'd7, 32'hFEE0_0060)));
        step(1);
        chk("wtid_edge", 128'(pulse_edge), 128'(e0 + T));
        chk("wtid_count", 128'(pulses), 128'(p0 + 1));
        chk("wtid_cnt", 128'(err_cnt_o), 128'(LOG ? 2 : 0));
        chk("wtid_adr", 128'(err_adr_o), 128'(LOG ? 32'hFEE0_0060 : 32'hFFFF_FFFF));
        req = '0;
        step(2);
        chk("wtid_idle", 128'(busy_o), 128'(0));

        // reset mid-WAIT at counter 500
        req = mk_req(8'd9, 32'hFEE0_0070, 1'b0);
        e0  = edge_cnt + 1;
        step_to(e0 + 500);
        chk("mid_busy", 128'(busy_o), 128'(1));
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(busy_o), 128'(0));
        chk("mid_rst_resp", 128'(resp_o), 128'(0));
        chk("mid_rst_cnt", 128'(err_cnt_o), 128'(0));
        chk("mid_rst_adr", 128'(err_adr_o), 128'(32'hFFFF_FFFF));
        req = '0;
        step(2);
        rst_ni = 1'b1;
        p0 = pulses;
        step(T + 10);
        chk("mid_no_pulse", 128'(pulses), 128'(p0));
        chk("mid_idle", 128'(busy_o), 128'(0));

        // TIMEOUT=4 smoke: read tid 7, then write tid 2
        req4 = mk_req(8'd7, 32'hFEE0_0020, 1'b0);
        e0   = edge_cnt + 1;
        step_to(e0 + T4 - 1);
        chk("s4_busy_pre", 128'(busy4_o), 128'(1));
        chk("s4_no_early", 128'(pulses4), 128'(0));
        step(1);
        chk("s4_pulse", 128'(resp4_o), 128'(err_pulse(8'd7, 32'hFEE0_0020)));
        step(1);
        chk("s4_drain", 128'(busy4_o), 128'(0));
        chk("s4_edge", 128'(pulse4_edge), 128'(e0 + T4));
        chk("s4_cnt", 128'(err_cnt4_o), 128'(LOG ? 1 : 0));
        req4 = '0;
        step(2);

        req4 = mk_req(8'd2, 32'hFEE0_0040, 1'b1);
        e0   = edge_cnt + 1;
        step_to(e0 + T4);
        chk("s4w_pulse", 128'(resp4_o), 128'(err_pulse(8'd2, 32'hFEE0_0040)));
        step(1);
        chk("s4w_edge", 128'(pulse4_edge), 128'(e0 + T4));
        chk("s4w_count", 128'(pulses4), 128'(2));
        chk("s4w_adr", 128'(err_adr4_o), 128'(LOG ? 32'hFEE0_0040 : 32'hFFFF_FFFF));
        req4 = '0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fta_io_timeout64.md
FTA_IO_TIMEOUT64 -- requirements
Module: fta_io_timeout64

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: bus cycles allowed between request issue and device response.
REQ-002 SHALL have parameter CNTW, default 10: width of the timeout counter; TIMEOUT SHALL be at most 2**CNTW.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on posedge clk_i.
REQ-004 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, fta_cmd_request64_t: monitored copy of the bridge's registered 64-bit master request.
REQ-006 SHALL have port resp_i, input, fta_cmd_response64_t: monitored merged device response.
REQ-007 SHALL have port resp_o, output, fta_cmd_response64_t: synthesized error response, wired as a bridge response channel.
REQ-008 SHALL have port busy_o, output, 1: a request is being timed.
REQ-009 SHALL have port err_cnt_o, output, 16: saturating count of timeouts.
REQ-010 SHALL have port err_adr_o, output, 32: padr of the most recent timed-out request.

Function
REQ-011 SHALL define a new request as req.cyc & req.stb & (cyc was low last cycle | req.tid != captured tid).
REQ-012 SHALL implement states IDLE, WAIT, ERR, DRAIN.
REQ-013 IDLE: on a new request, SHALL capture tid, padr and we, clear the counter, and enter WAIT the next cycle.
REQ-014 WAIT: SHALL increment the counter by 1 each cycle.
REQ-015 WAIT: if resp_i.ack | resp_i.err | resp_i.rty with resp_i.tid == captured tid, SHALL return to IDLE.
REQ-016 WAIT: otherwise, when the counter equals TIMEOUT-1, SHALL enter ERR.
REQ-017 A matching response in the same cycle the counter reaches TIMEOUT-1 SHALL win: go to IDLE, no error.
REQ-018 WAIT: if req.cyc drops, SHALL return to IDLE without error (master abandoned the request).
REQ-019 ERR: SHALL last exactly one cycle and drive, registered, one response pulse on resp_o.
- Pulse fields: err=1, ack=0, rty=0, tid = captured tid, adr = captured padr, dat=0, pri=0, next=0, stall=0.
REQ-020 ERR: SHALL then enter DRAIN.
REQ-021 DRAIN: SHALL hold until req.cyc==0 or a new request (per REQ-011) occurs.
REQ-022 DRAIN: a new request SHALL be captured as in IDLE, going directly to WAIT.
REQ-023 A same-tid request held with cyc high SHALL never re-arm the timer.
REQ-024 resp_o SHALL be all-zero in every cycle except the ERR pulse.
REQ-025 busy_o SHALL be 1 in WAIT and ERR, and 0 in IDLE and DRAIN.
REQ-026 Latency SHALL be as follows:
- ERR pulse appears on resp_o exactly TIMEOUT+1 cycles after the cycle the new request is sampled.
- No more than one error pulse SHALL be produced per captured request.
REQ-027 Reads and writes SHALL be timed identically.

Reset
REQ-028 While rst_ni==0, the block SHALL asynchronously force:
- state IDLE, counter 0, resp_o 0, busy_o 0, err_cnt_o 0, err_adr_o 32'hFFFFFFFF.
REQ-029 Reset mid-WAIT or mid-ERR SHALL abort with no error pulse emitted after reset deasserts.

Configuration
REQ-030 Macro FTA_IO_TIMEOUT_LOG_EN defined SHALL enable error logging:
- err_cnt_o increments by 1 in each ERR cycle, saturating at 16'hFFFF.
- err_adr_o loads the captured padr in each ERR cycle.
REQ-031 Macro FTA_IO_TIMEOUT_LOG_EN undefined: err_cnt_o and err_adr_o SHALL remain present, tied to 0 and 32'hFFFFFFFF, with no logging logic.

Structure
REQ-032 SHALL use fta_cmd_request64_t and fta_cmd_response64_t from fta_bus_pkg.
REQ-033 The state encoding enum SHALL be added to fta_bus_pkg as fta_io_timeout_state_t.
REQ-034 The counter SHALL be the sub-module fta_io_timeout_ctr, with clear, enable, and terminal-count outputs.

Verification
REQ-035 Read, tid=5, padr=32'hFEE00010, ack with tid 5 after 3 cycles -> no err pulse, busy_o 1 for 3 cycles.
REQ-036 Read, tid=7, padr=32'hFEE00020, no response -> one err pulse with tid 7, adr 32'hFEE00020 at cycle TIMEOUT+1; err_cnt_o=1 with LOG_EN.
REQ-037 Ack with tid 7 in the exact timeout cycle -> no err pulse, state IDLE.
REQ-038 Ack carrying a wrong tid (3) during WAIT -> ignored; err pulse still issued at timeout.
REQ-039 cyc held high after the err pulse, then new tid 8 -> DRAIN exits, timing restarts; exactly one pulse for tid 7.
REQ-040 rst_ni low at counter=500 -> all outputs reset immediately; no pulse after release; TIMEOUT=4 smoke run repeats REQ-036.
